// File: rtl/sram_ws_pkg.sv
// Shared types and helpers for the wait-stated SRAM model: FSM states,
// wait-counter sizing and the per-byte even-parity function.
package sram_ws_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACCESS
   } state_t;

   localparam int unsigned MAX_WAIT = 15;
   localparam int unsigned CNT_W    = $clog2(MAX_WAIT + 1);

   function automatic logic byte_par(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/sram_ws_array.sv
// Byte-lane SRAM storage with registered read port; per-lane even parity
// is stored and checked only when SRAM_WS_PARITY_EN is defined.
module sram_ws_array
   import sram_ws_pkg::*;
#(
   parameter int unsigned ADDR_W = 19,
   parameter int unsigned DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W/8-1:0]   be,
   input  logic [DATA_W-1:0]     wdata,
   input  logic                  par_inj,
   output logic [DATA_W-1:0]     rdata,
   output logic                  perr
);

   localparam int unsigned LANES = DATA_W / 8;

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned l = 0; l < LANES; l++) begin
            if (be[l]) mem[addr][8*l +: 8] <= wdata[8*l +: 8];
         end
      end
   end

   // Read register is reset so o_data starts at zero; the array itself is not.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)   rdata <= '0;
      else if (re) rdata <= mem[addr];
   end

`ifdef SRAM_WS_PARITY_EN
   logic [LANES-1:0] par_mem [2**ADDR_W];
   logic [LANES-1:0] par_calc;

   always_comb begin
      par_calc = '0;
      for (int unsigned l = 0; l < LANES; l++) par_calc[l] = byte_par(mem[addr][8*l +: 8]);
   end

   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned l = 0; l < LANES; l++) begin
            if (be[l]) par_mem[addr][l] <= byte_par(wdata[8*l +: 8]) ^ par_inj;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)   perr <= 1'b0;
      else if (re) perr <= |(par_calc ^ par_mem[addr]);
      else if (we) perr <= 1'b0;
   end
`else
   logic unused_par;
   assign unused_par = par_inj;
   assign perr       = 1'b0;
`endif

endmodule

// File: rtl/sram_ws.sv
// Wait-stated single-port SRAM front end: request capture, IDLE/WAIT/ACCESS
// sequencing and ack generation. Optional parity via SRAM_WS_PARITY_EN.
module sram_ws
   import sram_ws_pkg::*;
#(
   parameter int unsigned ADDR_W      = 19,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_req,
   input  logic                  i_wr_n,
   input  logic [ADDR_W-1:0]     i_addr,
   input  logic [DATA_W/8-1:0]   i_be,
   input  logic [DATA_W-1:0]     i_data,
   input  logic                  i_par_inj,
   output logic                  o_ready,
   output logic                  o_ack,
   output logic [DATA_W-1:0]     o_data,
   output logic                  o_perr
);

   localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

   state_t               state, state_nx;
   logic [CNT_W-1:0]     cnt;
   logic                 wr_n_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W/8-1:0]  be_q;
   logic [DATA_W-1:0]    data_q;
   logic                 inj_q;
   logic                 ack_q;
   logic                 accept;
   logic                 acc_we;
   logic                 acc_re;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (i_req) state_nx = (WAIT_STATES > 0) ? WAIT : ACCESS;
         WAIT:    if (cnt == '0) state_nx = ACCESS;
         ACCESS:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      o_ready = (state == IDLE);
      accept  = (state == IDLE) && i_req;
      acc_we  = (state == ACCESS) && !wr_n_q;
      acc_re  = (state == ACCESS) && wr_n_q;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt    <= '0;
         ack_q  <= 1'b0;
         wr_n_q <= 1'b1;
         addr_q <= '0;
         be_q   <= '0;
         data_q <= '0;
         inj_q  <= 1'b0;
      end else begin
         ack_q <= (state == ACCESS);
         if (accept) begin
            cnt    <= CNT_LOAD;
            wr_n_q <= i_wr_n;
            addr_q <= i_addr;
            be_q   <= i_be;
            data_q <= i_data;
            inj_q  <= i_par_inj;
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign o_ack = ack_q;

   sram_ws_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk     (i_clk),
      .reset   (i_reset),
      .we      (acc_we),
      .re      (acc_re),
      .addr    (addr_q),
      .be      (be_q),
      .wdata   (data_q),
      .par_inj (inj_q),
      .rdata   (o_data),
      .perr    (o_perr)
   );

endmodule

// File: tb/tb_sram_ws.sv
// Randomized self-checking bench for sram_ws: an 8-bit/1-wait instance and a
// 32-bit/0-wait instance checked against a plain array reference model.
module tb_sram_ws;

   localparam int unsigned AW    = 6;
   localparam int unsigned DEPTH = 2**AW;
`ifdef SRAM_WS_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          req_a, wr_n_a, inj_a, ready_a, ack_a, perr_a;
   logic [AW-1:0] addr_a;
   logic [0:0]    be_a;
   logic [7:0]    data_a, rdata_a;

   logic          req_b, wr_n_b, inj_b, ready_b, ack_b, perr_b;
   logic [AW-1:0] addr_b;
   logic [3:0]    be_b;
   logic [31:0]   data_b, rdata_b;

   sram_ws #(.ADDR_W(AW), .DATA_W(8), .WAIT_STATES(1)) u_dut_a (
      .i_clk(clk), .i_reset(rst), .i_req(req_a), .i_wr_n(wr_n_a), .i_addr(addr_a),
      .i_be(be_a), .i_data(data_a), .i_par_inj(inj_a), .o_ready(ready_a),
      .o_ack(ack_a), .o_data(rdata_a), .o_perr(perr_a)
   );

   sram_ws #(.ADDR_W(AW), .DATA_W(32), .WAIT_STATES(0)) u_dut_b (
      .i_clk(clk), .i_reset(rst), .i_req(req_b), .i_wr_n(wr_n_b), .i_addr(addr_b),
      .i_be(be_b), .i_data(data_b), .i_par_inj(inj_b), .o_ready(ready_b),
      .o_ack(ack_b), .o_data(rdata_b), .o_perr(perr_b)
   );

   int unsigned checks = 0;
   int unsigned errors = 0;

   logic [7:0]  mem_a [DEPTH];
   logic [31:0] mem_b [DEPTH];
   logic [3:0]  bad_a [DEPTH];
   logic [3:0]  bad_b [DEPTH];
   logic [31:0] last_a = '0;
   logic [31:0] last_b = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input bit sel, input bit req, input bit wr_n, input int unsigned addr,
                        input logic [3:0] be, input logic [31:0] data, input bit inj);
      if (sel) begin
         req_b = req; wr_n_b = wr_n; addr_b = AW'(addr); be_b = be; data_b = data; inj_b = inj;
      end else begin
         req_a = req; wr_n_a = wr_n; addr_a = AW'(addr); be_a = be[0:0]; data_a = data[7:0]; inj_a = inj;
      end
   endtask

   task automatic sample(input bit sel, output logic ready, output logic ack,
                         output logic perr, output logic [31:0] rdata);
      if (sel) begin
         ready = ready_b; ack = ack_b; perr = perr_b; rdata = rdata_b;
      end else begin
         ready = ready_a; ack = ack_a; perr = perr_a; rdata = {24'h0, rdata_a};
      end
   endtask

   // Reference behaviour of one completed access; returns expected o_data / o_perr.
   task automatic model(input bit sel, input bit wr, input int unsigned addr, input logic [3:0] be,
                        input logic [31:0] data, input bit inj,
                        output logic [31:0] exp_d, output logic exp_p);
      if (wr) begin
         for (int l = 0; l < (sel ? 4 : 1); l++) begin
            if (be[l]) begin
               if (sel) begin
                  mem_b[addr][8*l +: 8] = data[8*l +: 8];
                  bad_b[addr][l] = inj;
               end else begin
                  mem_a[addr] = data[7:0];
                  bad_a[addr][0] = inj;
               end
            end
         end
         exp_d = sel ? last_b : last_a;
         exp_p = 1'b0;
      end else begin
         exp_d = sel ? mem_b[addr] : {24'h0, mem_a[addr]};
         exp_p = PAR && ((sel ? bad_b[addr] : bad_a[addr]) != 4'h0);
         if (sel) last_b = exp_d; else last_a = exp_d;
      end
   endtask

   task automatic access(input bit sel, input bit wr, input int unsigned addr, input logic [3:0] be,
                         input logic [31:0] data, input bit inj,
                         output logic [31:0] got_d, output logic got_p);
      logic        ready, ack, perr, done;
      logic [31:0] exp_d;
      logic        exp_p;
      int unsigned lat;
      string       pfx;
      pfx = sel ? "b" : "a";
      @(negedge clk);
      drive(sel, 1'b1, !wr, addr, be, data, inj);
      sample(sel, ready, ack, perr, got_d);
      check({pfx, "_ready_idle"}, ready, 1'b1);
      @(posedge clk);
      #1;
      model(sel, wr, addr, be, data, inj, exp_d, exp_p);
      // scramble inputs after acceptance; the DUT must use its captured copy
      drive(sel, 1'b0, $urandom_range(0, 1), $urandom_range(0, DEPTH-1), 4'($urandom),
            $urandom, $urandom_range(0, 1));
      lat  = 0;
      done = 1'b0;
      got_p = 1'b0;
      while (lat < 20 && !done) begin
         @(posedge clk);
         #1;
         lat++;
         sample(sel, ready, ack, perr, got_d);
         done = ack;
      end
      check({pfx, "_ack_latency"}, lat, sel ? 32'd1 : 32'd2);
      if (done) begin
         got_p = perr;
         check({pfx, "_ready_on_ack"}, ready, 1'b1);
         check({pfx, wr ? "_data_hold" : "_read_data"}, got_d, exp_d);
         if (!wr) check({pfx, "_perr"}, perr, exp_p);
         @(posedge clk);
         #1;
         sample(sel, ready, ack, perr, got_d);
         check({pfx, "_ack_pulse"}, ack, 1'b0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic        p, ready, ack, perr;
      int unsigned acks;

      drive(1'b0, 1'b0, 1'b1, 0, 4'h0, 32'h0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 0, 4'h0, 32'h0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int s = 0; s < 2; s++) begin
         @(negedge clk);
         sample(s[0], ready, ack, perr, d);
         check("reset_ready", ready, 1'b1);
         check("reset_ack", ack, 1'b0);
         check("reset_data", d, 32'h0);
         check("reset_perr", perr, 1'b0);
      end

      for (int unsigned i = 0; i < DEPTH; i++) begin
         access(1'b0, 1'b1, i, 4'hF, $urandom, 1'b0, d, p);
         access(1'b1, 1'b1, i, 4'hF, $urandom, 1'b0, d, p);
      end

      access(1'b0, 1'b1, 'h10, 4'h1, 32'hA5, 1'b0, d, p);
      access(1'b0, 1'b0, 'h10, 4'h0, 32'h0, 1'b0, d, p);
      check("a_read_a5", d, 32'hA5);

      access(1'b1, 1'b1, 'h05, 4'hF, 32'h1122_3344, 1'b0, d, p);
      access(1'b1, 1'b1, 'h05, 4'h5, 32'hAABB_CCDD, 1'b0, d, p);
      access(1'b1, 1'b0, 'h05, 4'h0, 32'h0, 1'b0, d, p);
      check("b_byte_merge", d, 32'h11BB_33DD);

      access(1'b1, 1'b1, 'h05, 4'h0, 32'hFFFF_FFFF, 1'b0, d, p);
      access(1'b1, 1'b0, 'h05, 4'h0, 32'h0, 1'b0, d, p);
      check("b_be_zero_noop", d, 32'h11BB_33DD);
      access(1'b0, 1'b1, 'h10, 4'h0, 32'h00, 1'b0, d, p);
      access(1'b0, 1'b0, 'h10, 4'h0, 32'h0, 1'b0, d, p);
      check("a_be_zero_noop", d, 32'hA5);

      // continuous read requests on the zero-wait instance
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, 'h05, 4'h0, 32'h0, 1'b0);
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         sample(1'b1, ready, ack, perr, d);
         if (ack) begin
            acks++;
            check("b_stream_ready", ready, 1'b1);
            check("b_stream_data", d, mem_b['h05]);
         end
      end
      drive(1'b1, 1'b0, 1'b1, 'h05, 4'h0, 32'h0, 1'b0);
      check("b_stream_acks", acks, 5);
      last_b = mem_b['h05];
      repeat (2) @(posedge clk);

      // reset during WAIT aborts the write and clears o_data
      access(1'b0, 1'b1, 'h21, 4'h1, 32'h12, 1'b0, d, p);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 'h21, 4'h1, 32'hFF, 1'b0);
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b1, 0, 4'h0, 32'h0, 1'b0);
      #2;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      last_a = '0;
      last_b = '0;
      acks = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (ack_a) acks++;
      end
      check("a_abort_no_ack", acks, 0);
      check("a_abort_data_rst", {24'h0, rdata_a}, 32'h0);
      check("b_data_rst", rdata_b, 32'h0);
      access(1'b0, 1'b0, 'h21, 4'h0, 32'h0, 1'b0, d, p);
      check("a_abort_kept", d, 32'h12);

`ifdef SRAM_WS_PARITY_EN
      access(1'b0, 1'b1, 'h30, 4'h1, 32'h5A, 1'b1, d, p);
      access(1'b0, 1'b0, 'h30, 4'h0, 32'h0, 1'b0, d, p);
      check("a_par_inj_err", p, 1'b1);
      access(1'b0, 1'b1, 'h30, 4'h1, 32'h5A, 1'b0, d, p);
      access(1'b0, 1'b0, 'h30, 4'h0, 32'h0, 1'b0, d, p);
      check("a_par_clean", p, 1'b0);
`endif

      for (int i = 0; i < 300; i++) begin
         access($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, DEPTH-1),
                4'($urandom), $urandom, ($urandom_range(0, 3) == 0), d, p);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
